// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared definitions for the pipeline control/hazard slice: field widths,
// aluop and forwarding-select encodings, the decoded control bundle, and the
// forwarding-select helper.
package ctrl_pkg;

    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 2;

    // aluop encodings produced by the decoder
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

    // EX operand source selects
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Decoded control bundle as carried in the ID/EX register
    typedef struct packed {
        logic               regdst;
        logic               alusrc;
        logic               memtoreg;
        logic               branch;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    localparam int    CTRL_W      = $bits(ctrl_t);
    localparam ctrl_t CTRL_BUBBLE = '0;

    // Operand source for one EX source register; the EX/MEM result is newer,
    // so it is checked first. r0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src_reg,
        input logic              mem_rw,
        input logic [REG_AW-1:0] mem_wr,
        input logic              wb_rw,
        input logic [REG_AW-1:0] wb_wr
    );
        if (mem_rw && (mem_wr != '0) && (mem_wr == src_reg)) begin
            return FWD_EXMEM;
        end
        if (wb_rw && (wb_wr != '0) && (wb_wr == src_reg)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_hazard_detect.sv
// Combinational hazard detection: load-use stall and taken-branch detection
// from the instruction in EX against the register fields of the one in ID.
module hazard_detect
    import ctrl_pkg::*;
(
    input  logic              ex_mem_read,
    input  logic              ex_branch,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_alu_zero,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              stall,
    output logic              taken
);

    // A load whose destination feeds the ID instruction must wait one cycle;
    // a branch in EX is taken when the ALU compare is zero.
    always_comb begin
        stall = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        taken = ex_branch && ex_alu_zero;
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Pipeline control registers (ID/EX, EX/MEM, MEM/WB) plus stall, flush and
// EX-stage forwarding steering for the 5-stage core.
module ctrl_pipe_hazard #(
    parameter int REG_AW  = ctrl_pkg::REG_AW,
    parameter int ALUOP_W = ctrl_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_regdst,
    input  logic               id_alusrc,
    input  logic               id_memtoreg,
    input  logic               id_branch,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               ex_alu_zero,
    output logic               ex_regdst,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               mem_branch,
    output logic               mem_mem_read,
    output logic               mem_mem_write,
    output logic               wb_memtoreg,
    output logic               wb_reg_write,
    output logic               mem_reg_write,
    output logic [REG_AW-1:0]  mem_write_reg,
    output logic [REG_AW-1:0]  wb_write_reg,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               pc_src,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
);

    import ctrl_pkg::*;

    // ID/EX
    ctrl_t             idex_ctrl_q, idex_ctrl_d;
    logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    // EX/MEM
    logic              mem_branch_q, mem_branch_d;
    logic              mem_mem_read_q, mem_mem_read_d;
    logic              mem_mem_write_q, mem_mem_write_d;
    logic              mem_memtoreg_q, mem_memtoreg_d;
    logic              mem_reg_write_q, mem_reg_write_d;
    logic [REG_AW-1:0] mem_write_reg_q, mem_write_reg_d;
    // MEM/WB
    logic              wb_memtoreg_q, wb_memtoreg_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic [REG_AW-1:0] wb_write_reg_q, wb_write_reg_d;

    logic              stall;
    logic              taken;
    logic              bubble;
    logic [REG_AW-1:0] ex_write_reg;

    hazard_detect u_hazard_detect (
        .ex_mem_read (idex_ctrl_q.mem_read),
        .ex_branch   (idex_ctrl_q.branch),
        .ex_rt       (ex_rt_q),
        .ex_alu_zero (ex_alu_zero),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .stall       (stall),
        .taken       (taken)
    );

    assign bubble       = stall || taken;
    assign ex_write_reg = idex_ctrl_q.regdst ? ex_rd_q : ex_rt_q;

    // Next-state for all three stage registers; ID/EX takes a bubble on stall or taken branch
    always_comb begin
        idex_ctrl_d     = CTRL_BUBBLE;
        ex_rs_d         = '0;
        ex_rt_d         = '0;
        ex_rd_d         = '0;
        if (!bubble) begin
            idex_ctrl_d.regdst    = id_regdst;
            idex_ctrl_d.alusrc    = id_alusrc;
            idex_ctrl_d.memtoreg  = id_memtoreg;
            idex_ctrl_d.branch    = id_branch;
            idex_ctrl_d.reg_write = id_reg_write;
            idex_ctrl_d.mem_read  = id_mem_read;
            idex_ctrl_d.mem_write = id_mem_write;
            idex_ctrl_d.aluop     = id_aluop;
            ex_rs_d               = id_rs;
            ex_rt_d               = id_rt;
            ex_rd_d               = id_rd;
        end
        mem_branch_q_next_unused: begin end
        mem_branch_d    = idex_ctrl_q.branch;
        mem_mem_read_d  = idex_ctrl_q.mem_read;
        mem_mem_write_d = idex_ctrl_q.mem_write;
        mem_memtoreg_d  = idex_ctrl_q.memtoreg;
        mem_reg_write_d = idex_ctrl_q.reg_write;
        mem_write_reg_d = ex_write_reg;
        wb_memtoreg_d   = mem_memtoreg_q;
        wb_reg_write_d  = mem_reg_write_q;
        wb_write_reg_d  = mem_write_reg_q;
    end

    // Stage registers; reset turns every stage into a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_ctrl_q     <= CTRL_BUBBLE;
            ex_rs_q         <= '0;
            ex_rt_q         <= '0;
            ex_rd_q         <= '0;
            mem_branch_q    <= 1'b0;
            mem_mem_read_q  <= 1'b0;
            mem_mem_write_q <= 1'b0;
            mem_memtoreg_q  <= 1'b0;
            mem_reg_write_q <= 1'b0;
            mem_write_reg_q <= '0;
            wb_memtoreg_q   <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_write_reg_q  <= '0;
        end else begin
            idex_ctrl_q     <= idex_ctrl_d;
            ex_rs_q         <= ex_rs_d;
            ex_rt_q         <= ex_rt_d;
            ex_rd_q         <= ex_rd_d;
            mem_branch_q    <= mem_branch_d;
            mem_mem_read_q  <= mem_mem_read_d;
            mem_mem_write_q <= mem_mem_write_d;
            mem_memtoreg_q  <= mem_memtoreg_d;
            mem_reg_write_q <= mem_reg_write_d;
            mem_write_reg_q <= mem_write_reg_d;
            wb_memtoreg_q   <= wb_memtoreg_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_write_reg_q  <= wb_write_reg_d;
        end
    end

    // PC/IF-ID steering and forwarding selects; a taken branch overrides a stall,
    // and while reset is held the front end is frozen and IF/ID is flushed
    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b1;
        pc_src     = 1'b0;
        fwd_a      = FWD_RF;
        fwd_b      = FWD_RF;
        if (rst_n) begin
            pc_write   = taken || !stall;
            ifid_write = taken || !stall;
            ifid_flush = taken;
            pc_src     = taken;
            fwd_a      = fwd_sel(ex_rs_q, mem_reg_write_q, mem_write_reg_q,
                                 wb_reg_write_q, wb_write_reg_q);
            fwd_b      = fwd_sel(ex_rt_q, mem_reg_write_q, mem_write_reg_q,
                                 wb_reg_write_q, wb_write_reg_q);
        end
    end

    assign ex_regdst     = idex_ctrl_q.regdst;
    assign ex_alusrc     = idex_ctrl_q.alusrc;
    assign ex_aluop      = idex_ctrl_q.aluop;
    assign mem_branch    = mem_branch_q;
    assign mem_mem_read  = mem_mem_read_q;
    assign mem_mem_write = mem_mem_write_q;
    assign mem_reg_write = mem_reg_write_q;
    assign mem_write_reg = mem_write_reg_q;
    assign wb_memtoreg   = wb_memtoreg_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_write_reg  = wb_write_reg_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard: reset, R-type flow, load-use stall,
// forwarding priority, branch flush and flush/stall/reset interaction.
module tb_ctrl_pipe_hazard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_regdst, id_alusrc, id_memtoreg, id_branch;
    logic       id_reg_write, id_mem_read, id_mem_write;
    logic [1:0] id_aluop;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_alu_zero;
    logic       ex_regdst, ex_alusrc;
    logic [1:0] ex_aluop;
    logic       mem_branch, mem_mem_read, mem_mem_write;
    logic       wb_memtoreg, wb_reg_write, mem_reg_write;
    logic [4:0] mem_write_reg, wb_write_reg;
    logic       pc_write, ifid_write, ifid_flush, pc_src;
    logic [1:0] fwd_a, fwd_b;

    int checks = 0;
    int errors = 0;

    // control bundle order: {regdst, alusrc, memtoreg, branch, reg_write, mem_read, mem_write}
    localparam logic [6:0] C_NOP   = 7'b0000000;
    localparam logic [6:0] C_RTYPE = 7'b1000100;
    localparam logic [6:0] C_LW    = 7'b0110110;
    localparam logic [6:0] C_BEQ   = 7'b0001000;
    localparam logic [6:0] C_BRLD  = 7'b0001010;

    ctrl_pipe_hazard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_regdst     (id_regdst),
        .id_alusrc     (id_alusrc),
        .id_memtoreg   (id_memtoreg),
        .id_branch     (id_branch),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .id_aluop      (id_aluop),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .ex_alu_zero   (ex_alu_zero),
        .ex_regdst     (ex_regdst),
        .ex_alusrc     (ex_alusrc),
        .ex_aluop      (ex_aluop),
        .mem_branch    (mem_branch),
        .mem_mem_read  (mem_mem_read),
        .mem_mem_write (mem_mem_write),
        .wb_memtoreg   (wb_memtoreg),
        .wb_reg_write  (wb_reg_write),
        .mem_reg_write (mem_reg_write),
        .mem_write_reg (mem_write_reg),
        .wb_write_reg  (wb_write_reg),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .pc_src        (pc_src),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic id_set(input logic [6:0] ctl, input logic [1:0] aluop,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        {id_regdst, id_alusrc, id_memtoreg, id_branch,
         id_reg_write, id_mem_read, id_mem_write} = ctl;
        id_aluop = aluop;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
    endtask

    // advance one clock edge; inputs change 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // 1: reset held three cycles with reg_write asserted at ID
        rst_n       = 1'b0;
        ex_alu_zero = 1'b0;
        id_set(C_RTYPE, 2'b10, 5'd1, 5'd2, 5'd3);
        step(); step(); step();
        check("rst ex_aluop", 32'(ex_aluop), 32'd0);
        check("rst ex_regdst", 32'(ex_regdst), 32'd0);
        check("rst mem_reg_write", 32'(mem_reg_write), 32'd0);
        check("rst wb_reg_write", 32'(wb_reg_write), 32'd0);
        check("rst mem_write_reg", 32'(mem_write_reg), 32'd0);
        check("rst pc_write", 32'(pc_write), 32'd0);
        check("rst ifid_write", 32'(ifid_write), 32'd0);
        check("rst ifid_flush", 32'(ifid_flush), 32'd1);
        rst_n = 1'b1;
        id_set(C_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
        settle();
        check("rel pc_write", 32'(pc_write), 32'd1);
        check("rel ifid_flush", 32'(ifid_flush), 32'd0);

        // 2: add r3,r1,r2 through the pipe
        id_set(C_RTYPE, 2'b10, 5'd1, 5'd2, 5'd3);
        step();
        id_set(C_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
        settle();
        check("add ex_aluop", 32'(ex_aluop), 32'd2);
        check("add ex_regdst", 32'(ex_regdst), 32'd1);
        step();
        check("add mem_write_reg", 32'(mem_write_reg), 32'd3);
        check("add mem_reg_write", 32'(mem_reg_write), 32'd1);
        step();
        check("add wb_reg_write", 32'(wb_reg_write), 32'd1);
        check("add wb_write_reg", 32'(wb_write_reg), 32'd3);
        step(); step();

        // 3: lw r2,0(r1) then add r4,r2,r5
        id_set(C_LW, 2'b00, 5'd1, 5'd2, 5'd0);
        step();
        id_set(C_RTYPE, 2'b10, 5'd2, 5'd5, 5'd4);
        settle();
        check("lu stall pc_write", 32'(pc_write), 32'd0);
        check("lu stall ifid_write", 32'(ifid_write), 32'd0);
        step();
        check("lu bubble ex_aluop", 32'(ex_aluop), 32'd0);
        check("lu bubble ex_regdst", 32'(ex_regdst), 32'd0);
        check("lu lw mem_mem_read", 32'(mem_mem_read), 32'd1);
        check("lu one-cycle pc_write", 32'(pc_write), 32'd1);
        step();
        id_set(C_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
        settle();
        check("lu add ex_aluop", 32'(ex_aluop), 32'd2);
        check("lu fwd_a", 32'(fwd_a), 32'b01);
        check("lu fwd_b", 32'(fwd_b), 32'b00);
        step(); step(); step();

        // 4: add r3; sub r3; add r6,r3,r3 -> newest producer wins
        id_set(C_RTYPE, 2'b10, 5'd1, 5'd2, 5'd3);
        step();
        id_set(C_RTYPE, 2'b10, 5'd4, 5'd5, 5'd3);
        step();
        id_set(C_RTYPE, 2'b10, 5'd3, 5'd3, 5'd6);
        step();
        id_set(C_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
        settle();
        check("fwd new fwd_a", 32'(fwd_a), 32'b10);
        check("fwd new fwd_b", 32'(fwd_b), 32'b10);
        // same pattern writing r0 -> never forwarded
        id_set(C_RTYPE, 2'b10, 5'd1, 5'd2, 5'd0);
        step();
        id_set(C_RTYPE, 2'b10, 5'd4, 5'd5, 5'd0);
        step();
        id_set(C_RTYPE, 2'b10, 5'd0, 5'd0, 5'd6);
        step();
        id_set(C_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
        settle();
        check("fwd r0 fwd_a", 32'(fwd_a), 32'b00);
        check("fwd r0 fwd_b", 32'(fwd_b), 32'b00);
        // only MEM/WB matches
        id_set(C_RTYPE, 2'b10, 5'd1, 5'd2, 5'd7);
        step();
        id_set(C_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
        step();
        id_set(C_RTYPE, 2'b10, 5'd7, 5'd0, 5'd8);
        step();
        id_set(C_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
        settle();
        check("fwd wb fwd_a", 32'(fwd_a), 32'b01);
        check("fwd wb fwd_b", 32'(fwd_b), 32'b00);
        step(); step(); step();

        // 5: beq taken
        id_set(C_BEQ, 2'b01, 5'd1, 5'd2, 5'd0);
        step();
        id_set(C_RTYPE, 2'b10, 5'd3, 5'd4, 5'd9);
        ex_alu_zero = 1'b1;
        settle();
        check("br pc_src", 32'(pc_src), 32'd1);
        check("br ifid_flush", 32'(ifid_flush), 32'd1);
        check("br pc_write", 32'(pc_write), 32'd1);
        step();
        ex_alu_zero = 1'b0;
        id_set(C_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
        settle();
        check("br squash ex_aluop", 32'(ex_aluop), 32'd0);
        check("br squash ex_regdst", 32'(ex_regdst), 32'd0);
        check("br mem_branch", 32'(mem_branch), 32'd1);
        step(); step();
        // beq not taken
        id_set(C_BEQ, 2'b01, 5'd1, 5'd2, 5'd0);
        step();
        id_set(C_RTYPE, 2'b10, 5'd3, 5'd4, 5'd9);
        settle();
        check("nbr pc_src", 32'(pc_src), 32'd0);
        check("nbr ifid_flush", 32'(ifid_flush), 32'd0);
        step();
        id_set(C_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
        settle();
        check("nbr ex_aluop", 32'(ex_aluop), 32'd2);
        step(); step(); step();

        // 6: load-use coincident with taken branch -> flush wins
        id_set(C_BRLD, 2'b01, 5'd1, 5'd2, 5'd0);
        step();
        id_set(C_RTYPE, 2'b10, 5'd2, 5'd5, 5'd4);
        ex_alu_zero = 1'b1;
        settle();
        check("both pc_write", 32'(pc_write), 32'd1);
        check("both ifid_write", 32'(ifid_write), 32'd1);
        check("both ifid_flush", 32'(ifid_flush), 32'd1);
        check("both pc_src", 32'(pc_src), 32'd1);
        step();
        ex_alu_zero = 1'b0;
        settle();
        check("both ex_regdst", 32'(ex_regdst), 32'd0);
        check("both ex_aluop", 32'(ex_aluop), 32'd0);
        check("both no residual stall", 32'(pc_write), 32'd1);
        id_set(C_NOP, 2'b00, 5'd0, 5'd0, 5'd0);
        step(); step(); step();
        // reset in the middle of a load-use stall
        id_set(C_LW, 2'b00, 5'd1, 5'd2, 5'd0);
        step();
        id_set(C_RTYPE, 2'b10, 5'd2, 5'd5, 5'd4);
        settle();
        check("mid stall pc_write", 32'(pc_write), 32'd0);
        rst_n = 1'b0;
        settle();
        check("mid rst ifid_flush", 32'(ifid_flush), 32'd1);
        check("mid rst pc_src", 32'(pc_src), 32'd0);
        step();
        rst_n = 1'b1;
        settle();
        check("post rst pc_write", 32'(pc_write), 32'd1);
        check("post rst ifid_write", 32'(ifid_write), 32'd1);
        check("post rst ex_aluop", 32'(ex_aluop), 32'd0);
        check("post rst mem_mem_read", 32'(mem_mem_read), 32'd0);
        check("post rst wb_reg_write", 32'(wb_reg_write), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
